// File: rtl/change_dispenser.sv
// change_dispenser: pays an overpayment back as 10/5 rupee coins, greedy, via a hopper handshake.
// Define CHANGE_ACK_TIMEOUT_EN to fault when a hopper ack takes ACK_TIMEOUT cycles.
module change_dispenser #(
  parameter int AMOUNT_W    = 6,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                clock,
  input  logic                resetN,
  input  logic                changeValid,
  input  logic [AMOUNT_W-1:0] changeAmount,
  output logic                changeReady,
  output logic                dispenseTen,
  output logic                dispenseFive,
  input  logic                hopperAck,
  input  logic                tenEmpty,
  input  logic                fiveEmpty,
  output logic                busy,
  output logic                done,
  output logic                fault,
  output logic [AMOUNT_W-1:0] remaining
);
  typedef enum logic [2:0] {IDLE, CHECK, SELECT, DISPENSE, DONE, FAULT} state_t;
  localparam logic [AMOUNT_W-1:0] TEN  = AMOUNT_W'(10);
  localparam logic [AMOUNT_W-1:0] FIVE = AMOUNT_W'(5);
  if (ACK_TIMEOUT < 1) begin : g_bad_timeout
    $error("ACK_TIMEOUT must be at least 1");
  end
  state_t state_q, state_d;
  logic [AMOUNT_W-1:0] rem_q, rem_d;
  logic coin_q, coin_d;
`ifdef CHANGE_ACK_TIMEOUT_EN
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_ff @(posedge clock or negedge resetN)
    if (!resetN) cnt_q <= '0;
    else         cnt_q <= cnt_d;
`endif
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      rem_q   <= '0;
      coin_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      coin_q  <= coin_d;
    end
  end
  // coin_q: 1 = ten-rupee coin requested, 0 = five
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    coin_d  = coin_q;
`ifdef CHANGE_ACK_TIMEOUT_EN
    cnt_d   = '0;
`endif
    case (state_q)
      IDLE:   if (changeValid) begin
        rem_d   = changeAmount;
        state_d = CHECK;
      end
      CHECK:  state_d = (rem_q % FIVE) != '0 ? FAULT : SELECT;
      SELECT: begin
        if (rem_q == '0) state_d = DONE;
        else if (rem_q >= TEN && !tenEmpty) begin
          state_d = DISPENSE;
          coin_d  = 1'b1;
        end else if (rem_q >= FIVE && !fiveEmpty) begin
          state_d = DISPENSE;
          coin_d  = 1'b0;
        end else state_d = FAULT;
      end
      DISPENSE: begin
        if (hopperAck) begin
          rem_d   = rem_q - (coin_q ? TEN : FIVE);
          state_d = SELECT;
        end
`ifdef CHANGE_ACK_TIMEOUT_EN
        else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) state_d = FAULT;
        else cnt_d = cnt_q + 1'b1;
`endif
      end
      DONE:    state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign changeReady  = state_q == IDLE;
  assign busy         = state_q != IDLE;
  assign done         = state_q == DONE;
  assign fault        = state_q == FAULT;
  assign dispenseTen  = state_q == DISPENSE && coin_q;
  assign dispenseFive = state_q == DISPENSE && !coin_q;
  assign remaining    = rem_q;
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: table vectors, hand sequences and random requests against a greedy-change model.
module tb_change_dispenser;
  logic clock = 1'b0;
  logic resetN = 1'b0;
  logic changeValid = 1'b0;
  logic [5:0] changeAmount = '0;
  logic changeReady, dispenseTen, dispenseFive, busy, done, fault;
  logic hopperAck = 1'b0;
  logic tenEmpty = 1'b0;
  logic fiveEmpty = 1'b0;
  logic [5:0] remaining;
  int n_cmp = 0;
  int n_fail = 0;

  change_dispenser dut (
    .clock(clock), .resetN(resetN), .changeValid(changeValid), .changeAmount(changeAmount),
    .changeReady(changeReady), .dispenseTen(dispenseTen), .dispenseFive(dispenseFive),
    .hopperAck(hopperAck), .tenEmpty(tenEmpty), .fiveEmpty(fiveEmpty), .busy(busy),
    .done(done), .fault(fault), .remaining(remaining)
  );

  always #5 clock = ~clock;

  typedef struct {
    int amt, te, fe, d, tens, fives, ok, rem, endc;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Greedy change from the rules: tens first while available, then fives.
  task automatic model(input int amt, input int te, input int fe, input int d,
                       output int tens, output int fives, output int ok, output int rem, output int endc);
    rem = amt;
    tens = 0;
    fives = 0;
    if (amt % 5 != 0) begin
      ok = 0;
      endc = 2;
      return;
    end
    if (!te) tens = rem / 10;
    rem -= 10 * tens;
    if (!fe) fives = rem / 5;
    rem -= 5 * fives;
    ok = (rem == 0);
    endc = 3 + (tens + fives) * (d + 2);
  endtask

  // Issues one request, plays the hopper with a d-cycle ack wait, observes until done/fault.
  task automatic run_txn(input int amt, input int te, input int fe, input int d,
                         output int tens, output int fives, output int ok, output int rem,
                         output int endc, output int firstc, output int both);
    int w;
    bit fin;
    tens = 0; fives = 0; ok = -1; rem = -1; endc = -1; firstc = -1; both = 0;
    w = 0; fin = 0;
    @(negedge clock);
    changeAmount = 6'(amt);
    tenEmpty = te[0];
    fiveEmpty = fe[0];
    hopperAck = 1'b0;
    changeValid = 1'b1;
    @(posedge clock);
    for (int c = 1; c <= 400 && !fin; c++) begin
      @(negedge clock);
      changeValid = 1'($urandom_range(0, 1));
      changeAmount = 6'($urandom);
      if (dispenseTen && dispenseFive) both = 1;
      if (dispenseTen || dispenseFive) begin
        if (firstc < 0) firstc = c;
        hopperAck = (w >= d);
        if (hopperAck) begin
          if (dispenseTen) tens++;
          else fives++;
          w = 0;
        end else w++;
      end else hopperAck = 1'($urandom_range(0, 1));
      if (done || fault) begin
        ok = int'(done);
        rem = int'(remaining);
        endc = c;
        fin = 1;
        changeValid = 1'b0;
        hopperAck = 1'b0;
      end
    end
    if (!fin) chk("txn_timeout", 0, 1);
  endtask

  task automatic check_txn(input string tag, input int amt, input int te, input int fe, input int d,
                           input int e_tens, input int e_fives, input int e_ok, input int e_rem,
                           input int e_end);
    int tens, fives, ok, rem, endc, firstc, both;
    run_txn(amt, te, fe, d, tens, fives, ok, rem, endc, firstc, both);
    chk({tag, "_tens"}, tens, e_tens);
    chk({tag, "_fives"}, fives, e_fives);
    chk({tag, "_done"}, ok, e_ok);
    chk({tag, "_rem"}, rem, e_rem);
    chk({tag, "_cycle"}, endc, e_end);
    chk({tag, "_first_coin"}, firstc, (e_tens + e_fives) > 0 ? 3 : -1);
    chk({tag, "_exclusive"}, both, 0);
    @(negedge clock);
    chk({tag, "_rem_hold"}, int'(remaining), e_rem);
    chk({tag, "_idle_ready"}, int'(changeReady), 1);
  endtask

  initial begin
    int hi, seen_fault, tens, fives, ok, rem, endc;
    tbl[0] = '{25, 0, 0, 2, 2, 1, 1, 0, 15};
    tbl[1] = '{20, 1, 0, 2, 0, 4, 1, 0, 19};
    tbl[2] = '{15, 0, 1, 2, 1, 0, 0, 5, 7};
    tbl[3] = '{0, 0, 0, 0, 0, 0, 1, 0, 3};
    tbl[4] = '{7, 0, 0, 0, 0, 0, 0, 7, 2};
    tbl[5] = '{60, 0, 0, 0, 6, 0, 1, 0, 15};
    tbl[6] = '{55, 1, 1, 1, 0, 0, 0, 55, 3};
    tbl[7] = '{35, 0, 0, 3, 3, 1, 1, 0, 23};

    #1;
    chk("rst_ready", int'(changeReady), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_disp", int'({dispenseTen, dispenseFive}), 0);
    chk("rst_rem", int'(remaining), 0);
    repeat (2) @(negedge clock);
    resetN = 1'b1;

    foreach (tbl[i])
      check_txn($sformatf("vec%0d", i), tbl[i].amt, tbl[i].te, tbl[i].fe, tbl[i].d,
                tbl[i].tens, tbl[i].fives, tbl[i].ok, tbl[i].rem, tbl[i].endc);

    // Reset in the middle of a coin request abandons the coin immediately.
    @(negedge clock);
    changeAmount = 6'd10; tenEmpty = 1'b0; fiveEmpty = 1'b0; changeValid = 1'b1; hopperAck = 1'b0;
    @(posedge clock);
    hi = 0;
    for (int c = 0; c < 10 && !hi; c++) begin
      @(negedge clock);
      changeValid = 1'b0;
      hi = int'(dispenseTen);
    end
    chk("mid_reset_reached_dispense", hi, 1);
    resetN = 1'b0;
    #1;
    chk("mid_reset_disp", int'({dispenseTen, dispenseFive}), 0);
    chk("mid_reset_ready", int'(changeReady), 1);
    chk("mid_reset_busy", int'(busy), 0);
    chk("mid_reset_rem", int'(remaining), 0);
    @(negedge clock);
    resetN = 1'b1;
    check_txn("after_reset", 5, 0, 0, 1, 0, 1, 1, 0, 6);

    // A request the hopper never acknowledges.
    @(negedge clock);
    changeAmount = 6'd10; changeValid = 1'b1; hopperAck = 1'b0;
    @(posedge clock);
    hi = 0;
    seen_fault = 0;
    rem = -1;
    for (int c = 1; c <= 130 && !seen_fault; c++) begin
      @(negedge clock);
      changeValid = 1'b0;
      if (dispenseTen) hi++;
      if (fault) begin
        seen_fault = 1;
        rem = int'(remaining);
      end
    end
`ifdef CHANGE_ACK_TIMEOUT_EN
    chk("timeout_high_cycles", hi, 15);
    chk("timeout_fault", seen_fault, 1);
    chk("timeout_rem", rem, 10);
`else
    chk("noack_high_cycles", hi, 128);
    chk("noack_no_fault", seen_fault, 0);
`endif
    resetN = 1'b0;
    @(negedge clock);
    resetN = 1'b1;

    for (int i = 0; i < 40; i++) begin
      int amt, te, fe, d;
      amt = $urandom_range(0, 63);
      te = ($urandom_range(0, 3) == 0);
      fe = ($urandom_range(0, 3) == 0);
      d = $urandom_range(0, 3);
      model(amt, te, fe, d, tens, fives, ok, rem, endc);
      check_txn($sformatf("rnd%0d_amt%0d", i, amt), amt, te, fe, d, tens, fives, ok, rem, endc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
